// File: rtl/alu_ctrl_pkg.sv
// Shared types for the shared-ALU request scheduler:
// op modes, FSM states, request bundle and op legality.
package alu_ctrl_pkg;

  localparam int DATA_W = 5;
  localparam int OP_W = 5;

  localparam logic [1:0] MODE_A  = 2'b10;
  localparam logic [1:0] MODE_B  = 2'b01;
  localparam logic [1:0] MODE_AB = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0]        mode;
    logic [2:0]        code;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_req_t;

  function automatic logic op_illegal(
    input logic [1:0] mode,
    input logic [2:0] code
  );
    logic bad;
    unique case (mode)
      MODE_A:  bad = (code == 3'd7);
      MODE_B:  bad = code[2] | (code[1:0] == 2'd3);
      MODE_AB: bad = code[2];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or
// after ptr, wrapping; returns one-hot grant and index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one fixed-latency ALU
// between N requesters, with local illegal-op rejection.
module alu_req_sched
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DATA_W,
  parameter int RESULT_LAT = 1,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]      req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_WIDTH:0]        rsp_data,
  output logic                       rsp_err,
  output logic [DATA_WIDTH-1:0]      alu_A,
  output logic [DATA_WIDTH-1:0]      alu_B,
  output logic [2:0]                 alu_a_op,
  output logic [1:0]                 alu_b_op,
  output logic                       alu_a_en,
  output logic                       alu_b_en,
  output logic                       alu_en,
  input  logic [DATA_WIDTH:0]        alu_C,
  output logic                       busy,
  output logic [7:0]                 err_cnt
);

  localparam int LAT_W =
    (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gidx;
  logic [N_REQ-1:0]  gnt;
  logic              gany;
  op_req_t           lane;
  op_req_t           cur;
  logic              lane_bad;
  logic [LAT_W-1:0]  lat_cnt;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  always_comb begin
    lane.mode = req_op[int'(gidx)*OP_W+3 +: 2];
    lane.code = req_op[int'(gidx)*OP_W +: 3];
    lane.a    = req_a[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    lane.b    = req_b[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    lane_bad  = op_illegal(lane.mode, lane.code);
  end

  assign req_ready =
    (rst_n && state == IDLE) ? gnt : '0;
  assign busy = (state != IDLE);

  // cur only loads on legal grants, so ALU-facing
  // outputs keep their last issued values otherwise
  assign alu_A    = cur.a;
  assign alu_B    = cur.b;
  assign alu_a_op = cur.code;
  assign alu_b_op = cur.code[1:0];
  assign alu_a_en = cur.mode[1];
  assign alu_b_en = cur.mode[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      lat_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_en    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gany) begin
            rsp_id <= gidx;
            if (gidx == ID_W'(N_REQ-1))
              ptr <= '0;
            else
              ptr <= gidx + 1'b1;
            if (lane_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            end else begin
              state   <= ISSUE;
              cur     <= lane;
              alu_en  <= 1'b1;
              rsp_err <= 1'b0;
            end
          end
        end
        ISSUE: begin
          alu_en  <= 1'b0;
          lat_cnt <= LAT_W'(RESULT_LAT-1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_data  <= alu_C;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sched.sv
// Scoreboard bench for alu_req_sched with a behavioural
// fixed-latency ALU attached to the ALU-side ports.
module tb_alu_req_sched;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int L  = 1;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*5-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW:0]     rsp_data;
  logic            rsp_err;
  logic [DW-1:0]   alu_A;
  logic [DW-1:0]   alu_B;
  logic [2:0]      alu_a_op;
  logic [1:0]      alu_b_op;
  logic            alu_a_en;
  logic            alu_b_en;
  logic            alu_en;
  logic [DW:0]     alu_C;
  logic            busy;
  logic [7:0]      err_cnt;

  alu_req_sched #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .RESULT_LAT (L),
    .ID_W       (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_a_op  (alu_a_op),
    .alu_b_op  (alu_b_op),
    .alu_a_en  (alu_a_en),
    .alu_b_en  (alu_b_en),
    .alu_en    (alu_en),
    .alu_C     (alu_C),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          err;
    logic [DW:0]   data;
  } exp_t;

  exp_t        sbq[$];
  int          gnt_log[$];
  logic [DW-1:0] la [N];
  logic [DW-1:0] lb [N];
  logic [4:0]    lop[N];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   alu_pulses = 0;
  int   last_gnt_cyc = 0;
  int   last_rsp_cyc = 0;
  logic [DW:0] last_data;
  logic        last_err;
  int   err_exp = 0;

  function automatic logic [DW:0] alu_f(
    input logic ae, input logic be,
    input logic [2:0] aop, input logic [1:0] bop,
    input logic [DW-1:0] a, input logic [DW-1:0] b
  );
    logic signed [DW:0] xa, xb, r;
    xa = signed'({a[DW-1], a});
    xb = signed'({b[DW-1], b});
    r  = '0;
    if (ae && !be) begin
      case (aop)
        3'd0: r = xa + xb;
        3'd1: r = xa - xb;
        3'd2: r = xa & xb;
        3'd3: r = xa | xb;
        3'd4: r = xa ^ xb;
        3'd5: r = -xa;
        default: r = xa;
      endcase
    end else if (!ae && be) begin
      case (bop)
        2'd0: r = xb;
        2'd1: r = -xb;
        default: r = xb + xb;
      endcase
    end else if (ae && be) begin
      case (bop)
        2'd0: r = xa + xb;
        2'd1: r = xb - xa;
        default: r = xa + xb + 1;
      endcase
    end
    return r;
  endfunction

  logic [DW:0] pipe [L];
  always @(posedge clk) begin
    if (alu_en)
      pipe[0] <= alu_f(alu_a_en, alu_b_en, alu_a_op,
                       alu_b_op, alu_A, alu_B);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_C = pipe[L-1];

  function automatic logic bad_op(input logic [4:0] op);
    case (op[4:3])
      2'b10:   return op[2:0] == 3'd7;
      2'b01:   return op[2] || op[1:0] == 2'd3;
      2'b11:   return op[2];
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t exp_of(input int i);
    exp_t e;
    e.id  = IW'(i);
    e.err = bad_op(lop[i]);
    e.data = e.err ? '0 :
      alu_f(lop[i][4], lop[i][3], lop[i][2:0],
            lop[i][1:0], la[i], lb[i]);
    return e;
  endfunction

  function automatic int pop_gnt();
    if (gnt_log.size() == 0) return -1;
    return gnt_log.pop_front();
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a,
                         input int b, input int op);
    la[i]  = DW'(a);
    lb[i]  = DW'(b);
    lop[i] = 5'(op);
    req_a[i*DW +: DW] = la[i];
    req_b[i*DW +: DW] = lb[i];
    req_op[i*5 +: 5]  = lop[i];
    req_valid[i] = 1'b1;
  endtask

  // one cycle: sample at negedge, drive at posedge+1
  task automatic tick();
    int   g;
    exp_t e;
    g = -1;
    @(negedge clk);
    cyc++;
    if (alu_en) alu_pulses++;
    if (rsp_valid && rsp_ready) begin
      last_rsp_cyc = cyc;
      last_data = rsp_data;
      last_err  = rsp_err;
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = sbq.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
    if (req_ready != '0) begin
      check("ready_onehot",
            32'($countones(req_ready)), 1);
      for (int i = 0; i < N; i++)
        if (req_ready[i]) g = i;
      check("ready_valid", 32'(req_valid[g]), 1);
      e = exp_of(g);
      sbq.push_back(e);
      gnt_log.push_back(g);
      last_gnt_cyc = cyc;
      if (e.err && err_exp < 255) err_exp++;
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((req_valid != '0 || sbq.size() != 0 ||
            busy) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= 300), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

  logic [IW-1:0] s_id;
  logic [DW:0]   s_data;
  logic          s_err;
  int            p0;
  int            n;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_en", 32'(alu_en), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_alu_A", 32'(alu_A), 0);
    req_valid = '0;
    rst_n = 1'b1;

    // basic add on req0 with latency check
    gnt_log.delete();
    p0 = alu_pulses;
    set_req(0, 7, 3, 5'b10_000);
    drain("t1");
    check("t1_gnt", 32'(pop_gnt()), 0);
    check("t1_lat", 32'(last_rsp_cyc - last_gnt_cyc),
          32'(L + 2));
    check("t1_pulses", 32'(alu_pulses - p0), 1);
    check("t1_data", 32'(last_data), 32'd10);

    // pointer=1, only req3: wrap case
    set_req(3, 1, 2, 5'b11_000);
    drain("t3");
    check("t3_gnt", 32'(pop_gnt()), 3);

    // pointer=0, req0+req1 together, twice
    set_req(0, -5, 4, 5'b01_001);
    set_req(1, 9, -2, 5'b10_100);
    drain("t4a");
    check("t4a_gnt0", 32'(pop_gnt()), 0);
    check("t4a_gnt1", 32'(pop_gnt()), 1);
    set_req(0, 3, 3, 5'b10_010);
    set_req(1, -1, 5, 5'b11_001);
    drain("t4b");
    check("t4b_gnt0", 32'(pop_gnt()), 0);
    check("t4b_gnt1", 32'(pop_gnt()), 1);

    // subtract with sign
    set_req(2, -16, 15, 5'b10_001);
    drain("t2");
    check("t2_gnt", 32'(pop_gnt()), 2);
    check("t2_data", 32'(last_data), 32'b100001);

    // illegal ops
    p0 = alu_pulses;
    set_req(1, 0, 0, 5'b10_111);
    drain("t5a");
    check("t5_ill_lat",
          32'(last_rsp_cyc - last_gnt_cyc), 1);
    set_req(1, 3, 3, 5'b00_000);
    drain("t5b");
    check("t5_pulses", 32'(alu_pulses - p0), 0);
    check("t5_err_cnt", 32'(err_cnt), 2);
    check("t5_err", 32'(last_err), 1);
    check("t5_data", 32'(last_data), 0);
    gnt_log.delete();

    // response back-pressure
    rsp_ready = 1'b0;
    set_req(0, 4, 4, 5'b10_000);
    set_req(1, 2, 1, 5'b01_010);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("t6_rsp_seen", 32'(rsp_valid), 1);
    s_id = rsp_id;
    s_data = rsp_data;
    s_err = rsp_err;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_valid", 32'(rsp_valid), 1);
      check("t6_id", 32'(rsp_id), 32'(s_id));
      check("t6_data", 32'(rsp_data), 32'(s_data));
      check("t6_err", 32'(rsp_err), 32'(s_err));
      check("t6_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    drain("t6");
    gnt_log.delete();

    // reset during WAIT
    p0 = alu_pulses;
    set_req(0, 5, 6, 5'b10_000);
    n = 0;
    while (alu_pulses == p0 && n < 10) begin
      tick();
      n++;
    end
    check("t7_issued", 32'(alu_pulses - p0), 1);
    rst_n = 1'b0;
    #1;
    check("t7_alu_en", 32'(alu_en), 0);
    check("t7_rsp_valid", 32'(rsp_valid), 0);
    check("t7_busy", 32'(busy), 0);
    sbq.delete();
    gnt_log.delete();
    req_valid = '0;
    err_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 1, 1, 5'b10_000);
    set_req(0, 2, 2, 5'b10_001);
    drain("t7");
    check("t7_gnt0", 32'(pop_gnt()), 0);
    check("t7_gnt1", 32'(pop_gnt()), 1);
    check("t7_err_cnt", 32'(err_cnt), 0);

    // random mix with random back-pressure
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rsp_ready = 1'b1;
    drain("rand");
    check("rand_err_cnt", 32'(err_cnt), 32'(err_exp));

    // err_cnt saturation
    for (int k = 0; k < 260; k++) begin
      set_req(2, 0, 0, k % 8);
      drain("sat");
    end
    check("sat_err_cnt", 32'(err_cnt), 32'(err_exp));
    check("sat_255", 32'(err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
